fwperiph_dma_fifo_target: RTL and testbench
===========================================

# fwperiph_dma_fifo_target

Wishbone target peripheral containing a single FIFO with DMA request handshake outputs, used as a DMA-paced data source/sink on the initiator ports of the DMA controller. Writes to the DATA register push the FIFO and reads pop it. Two level requests, `rd_req_o` (data available) and `wr_req_o` (space available), feed the controller's `dma_req_i` lines, and the controller's per-transfer acknowledges return on `rd_ack_i`/`wr_ack_i`.

## Interface
- `DEPTH`, 16: FIFO entries; power of 2, 2..256.
- `ADDR_WIDTH`, 32: Wishbone address width.
- `DATA_WIDTH`, 32: Wishbone data width and FIFO entry width.
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `t_adr`  in  ADDR_WIDTH: address; only `t_adr[3:2]` is decoded.
- `t_dat_w`  in  DATA_WIDTH: write data.
- `t_dat_r`  out  DATA_WIDTH: read data.
- `t_cyc`, `t_stb`, `t_we`  in  1: Wishbone cycle, strobe, write enable.
- `t_sel`  in  DATA_WIDTH/8: byte selects; ignored, all accesses are full-word.
- `t_ack`  out  1: transfer acknowledge.
- `t_err`  out  1: transfer error.
- `rd_req_o`  out  1: the FIFO holds at least RD_THRESH entries.
- `wr_req_o`  out  1: the FIFO has at least WR_THRESH free entries.
- `rd_ack_i`, `wr_ack_i`  in  1: single-cycle acknowledges from the DMA controller.

## Operation
- Register map (`t_adr[3:2]`):
  - 0 DATA: a write pushes, a read pops.
  - 1 STATUS: [31:16] count, [3] ovf, [2] udf, [1] full, [0] empty. Writing 1 to bit 3 or bit 2 clears that flag; other bits are read-only.
  - 2 CTRL: [31] en, [15:8] WR_THRESH, [7:0] RD_THRESH. Read/write.
  - 3: reads 0; writes are ignored and acked.
- Access acceptance: an access is accepted in any cycle with `t_cyc & t_stb & !t_ack & !t_err`.
  - On that clock edge the register or FIFO action is performed and exactly one of `t_ack`/`t_err` is registered high for one cycle.
  - `t_dat_r` is registered on the same edge.
- DATA write when full: `t_err`, data dropped, ovf set, count unchanged.
- DATA read when empty: `t_err`, `t_dat_r` = 0, udf set.
- FIFO implementation: circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, zero-extended into STATUS.
  - full = (count == DEPTH); empty = (count == 0).
- Request rule, evaluated every cycle from next-state count:
  - `rd_req_o` = en & (count >= RD_THRESH) & !rd_hold.
  - `wr_req_o` = en & (DEPTH - count >= WR_THRESH) & !wr_hold.
- Holdoff: `rd_ack_i` sets rd_hold and `wr_ack_i` sets wr_hold. Each hold clears on the next Wishbone access to DATA of the matching direction (pop for rd, push for wr), or when en = 0. This prevents a re-request before the acked bus cycle lands.
- A threshold of 0 is treated as 1. A threshold greater than DEPTH never requests.
- Clearing en does not flush the FIFO. Flushing happens only on reset.
- Reset values:
  - `t_ack`, `t_err`, `rd_req_o`, `wr_req_o` = 0; `t_dat_r` = 0.
  - Pointers and count = 0; ovf = udf = 0; holds = 0.
  - CTRL = 0x0000_0101 (en = 0, both thresholds = 1).

## Timing
- Access latency: `t_ack`/`t_err` is asserted in the cycle after acceptance. Back-to-back accesses with `t_stb` held therefore complete every 2 cycles.
- Read data: `t_dat_r` is valid in the same cycle as `t_ack` and holds until the next accepted read.
- count, full/empty and the requests are registered and update on the acceptance edge. A request is therefore visible in the same cycle as the `t_ack` that changed count.
- Ack holdoff: `rd_ack_i`/`wr_ack_i` sampled high on edge N forces the matching request low from cycle N+1.
- Same-edge ack and DATA access: if an ack and a matching-direction DATA access occur on the same edge, the hold is set, and it is then cleared by the access that follows.
- Simultaneous STATUS write-1-to-clear and a DATA error are impossible on a single port; at most one access occurs per cycle.
- Reset mid-transfer: an asserted `reset` drops `t_ack`/`t_err` and the requests immediately. A master cycle in progress is not acked and must be restarted by the master.

## Test plan
- Reset defaults: assert reset, release, read STATUS -> 0x0000_0001. Read CTRL -> 0x0000_0101. Both requests 0.
- Push/pop order (DEPTH = 16): set CTRL = 0x8000_0101, write 0x11..0x1F (15 words) -> STATUS count = 15. Reading 15 times returns 0x11..0x1F in order, then STATUS = 0x0000_0001. Pointers wrap with no data corruption over 3 full passes.
- Full/overflow: push 16 words -> full = 1, `wr_req_o` = 0. A 17th write -> `t_err`, ovf = 1, count = 16. Writing STATUS 0x8 -> ovf = 0.
- Empty/underflow: a read on empty -> `t_err`, `t_dat_r` = 0, udf = 1. A write of 0x4 clears udf.
- Thresholds: CTRL = 0x8000_0404. Push 3 words -> `rd_req_o` = 0. The 4th push -> `rd_req_o` = 1 in its ack cycle. `wr_req_o` = 1 until count = 13, then 0.
- Holdoff: with `rd_req_o` = 1, pulse `rd_ack_i` -> `rd_req_o` = 0 the next cycle and stays 0 while idle. One DATA read -> `rd_req_o` returns to 1 if count is still >= RD_THRESH.

Source files
------------

// File: rtl/fwperiph_dma_fifo_target_if.sv
// Wishbone target bus bundle for the DMA-paced FIFO peripheral.
interface fwperiph_dma_fifo_target_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   t_adr;
  logic [DATA_WIDTH-1:0]   t_dat_w;
  logic [DATA_WIDTH-1:0]   t_dat_r;
  logic                    t_cyc;
  logic                    t_stb;
  logic                    t_we;
  logic [DATA_WIDTH/8-1:0] t_sel;
  logic                    t_ack;
  logic                    t_err;

  modport master (output t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
                  input  t_dat_r, t_ack, t_err);
  modport slave  (input  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
                  output t_dat_r, t_ack, t_err);
endinterface

// File: rtl/fwperiph_dma_fifo_target.sv
// Wishbone FIFO target with level-based DMA read/write requests and
// per-direction holdoff after each controller acknowledge.
module fwperiph_dma_fifo_target #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  fwperiph_dma_fifo_target_if.slave   wb,
  output logic                        rd_req_o,
  output logic                        wr_req_o,
  input  logic                        rd_ack_i,
  input  logic                        wr_ack_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic          ovf, udf, en, en_nxt;
  logic [7:0]    rd_th, wr_th, rd_th_nxt, wr_th_nxt;
  logic          rd_hold, wr_hold, rd_hold_nxt, wr_hold_nxt;
  logic          accept, is_data, full, empty, push, pop, data_err;
  logic          ctrl_wr, stat_wr;
  logic [1:0]    adr;
  logic [8:0]    cnt9, free9, rd_th_eff, wr_th_eff;
  logic [DATA_WIDTH-1:0] rdata;
  logic          unused;

  assign unused   = ^{wb.t_sel, wb.t_adr[ADDR_WIDTH-1:4], wb.t_adr[1:0]};
  assign adr      = wb.t_adr[3:2];
  assign accept   = wb.t_cyc & wb.t_stb & ~wb.t_ack & ~wb.t_err;
  assign is_data  = (adr == 2'd0);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = accept &  wb.t_we & is_data & ~full;
  assign pop      = accept & ~wb.t_we & is_data & ~empty;
  assign data_err = accept & is_data & (wb.t_we ? full : empty);
  assign ctrl_wr  = accept & wb.t_we & (adr == 2'd2);
  assign stat_wr  = accept & wb.t_we & (adr == 2'd1);

  assign en_nxt    = ctrl_wr ? wb.t_dat_w[31]   : en;
  assign wr_th_nxt = ctrl_wr ? wb.t_dat_w[15:8] : wr_th;
  assign rd_th_nxt = ctrl_wr ? wb.t_dat_w[7:0]  : rd_th;

  always_comb begin
    count_nxt = count;
    if (push)     count_nxt = count + CW'(1);
    else if (pop) count_nxt = count - CW'(1);
  end

  // Ack wins over a same-edge access so the hold survives until the
  // access the controller is actually about to issue.
  always_comb begin
    rd_hold_nxt = rd_hold;
    wr_hold_nxt = wr_hold;
    if (accept & is_data & ~wb.t_we) rd_hold_nxt = 1'b0;
    if (accept & is_data &  wb.t_we) wr_hold_nxt = 1'b0;
    if (rd_ack_i) rd_hold_nxt = 1'b1;
    if (wr_ack_i) wr_hold_nxt = 1'b1;
    if (!en_nxt) begin
      rd_hold_nxt = 1'b0;
      wr_hold_nxt = 1'b0;
    end
  end

  // Threshold 0 behaves as 1; anything above DEPTH simply never matches.
  assign cnt9      = 9'(count_nxt);
  assign free9     = 9'(DEPTH) - cnt9;
  assign rd_th_eff = (rd_th_nxt == 8'd0) ? 9'd1 : {1'b0, rd_th_nxt};
  assign wr_th_eff = (wr_th_nxt == 8'd0) ? 9'd1 : {1'b0, wr_th_nxt};

  always_comb begin
    rdata = '0;
    case (adr)
      2'd0: rdata = empty ? '0 : mem[rptr];
      2'd1: rdata = DATA_WIDTH'({16'(count), 12'd0, ovf, udf, full, empty});
      2'd2: rdata = DATA_WIDTH'({en, 15'd0, wr_th, rd_th});
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb.t_ack   <= 1'b0;
      wb.t_err   <= 1'b0;
      wb.t_dat_r <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      en         <= 1'b0;
      wr_th      <= 8'd1;
      rd_th      <= 8'd1;
      rd_hold    <= 1'b0;
      wr_hold    <= 1'b0;
      rd_req_o   <= 1'b0;
      wr_req_o   <= 1'b0;
    end else begin
      wb.t_ack <= accept & ~data_err;
      wb.t_err <= data_err;
      if (accept & ~wb.t_we) wb.t_dat_r <= rdata;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      if (data_err & wb.t_we)          ovf <= 1'b1;
      else if (stat_wr & wb.t_dat_w[3]) ovf <= 1'b0;
      if (data_err & ~wb.t_we)         udf <= 1'b1;
      else if (stat_wr & wb.t_dat_w[2]) udf <= 1'b0;
      en       <= en_nxt;
      wr_th    <= wr_th_nxt;
      rd_th    <= rd_th_nxt;
      rd_hold  <= rd_hold_nxt;
      wr_hold  <= wr_hold_nxt;
      rd_req_o <= en_nxt & (cnt9 >= rd_th_eff) & ~rd_hold_nxt;
      wr_req_o <= en_nxt & (free9 >= wr_th_eff) & ~wr_hold_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= wb.t_dat_w;
  end
endmodule

// File: tb/tb_fwperiph_dma_fifo_target.sv
// Randomized bench for the DMA FIFO target against a queue-based model.
module tb_fwperiph_dma_fifo_target;
  localparam int DEPTH = 16;

  logic clock, reset, rd_req_o, wr_req_o, rd_ack_i, wr_ack_i;
  int   tests, fails;

  fwperiph_dma_fifo_target_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb();

  fwperiph_dma_fifo_target #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .wb(wb),
    .rd_req_o(rd_req_o), .wr_req_o(wr_req_o),
    .rd_ack_i(rd_ack_i), .wr_ack_i(wr_ack_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state
  logic [31:0] q[$];
  bit          m_en, m_ovf, m_udf, m_rh, m_wh;
  int          m_rth, m_wth;

  function automatic void model_reset();
    q.delete();
    m_en = 0; m_ovf = 0; m_udf = 0; m_rh = 0; m_wh = 0;
    m_rth = 1; m_wth = 1;
  endfunction

  function automatic bit exp_rq();
    int th = (m_rth == 0) ? 1 : m_rth;
    return m_en && (q.size() >= th) && !m_rh;
  endfunction

  function automatic bit exp_wq();
    int th = (m_wth == 0) ? 1 : m_wth;
    return m_en && ((DEPTH - q.size()) >= th) && !m_wh;
  endfunction

  function automatic logic [31:0] m_status();
    return {16'(q.size()), 12'h0, m_ovf, m_udf, q.size() == DEPTH, q.size() == 0};
  endfunction

  function automatic void model_acks(input bit rack, input bit wack);
    if (rack) m_rh = 1;
    if (wack) m_wh = 1;
    if (!m_en) begin m_rh = 0; m_wh = 0; end
  endfunction

  // One Wishbone access; returns observed {ack,err,rd_req,wr_req} and read
  // data along with what the model expects.
  task automatic bus(input bit we, input logic [1:0] a, input logic [31:0] wd,
                     input bit rack, input bit wack,
                     output logic [31:0] od, output logic [3:0] o,
                     output logic [31:0] ed, output logic [3:0] e);
    bit er;
    er = 0; ed = '0;
    @(negedge clock);
    wb.t_cyc = 1; wb.t_stb = 1; wb.t_we = we; wb.t_adr = {28'h0, a, 2'b00};
    wb.t_dat_w = wd; wb.t_sel = 4'hf; rd_ack_i = rack; wr_ack_i = wack;
    @(posedge clock); #1;
    od = wb.t_dat_r;
    o  = {wb.t_ack, wb.t_err, rd_req_o, wr_req_o};
    @(negedge clock);
    wb.t_cyc = 0; wb.t_stb = 0; wb.t_we = 0; rd_ack_i = 0; wr_ack_i = 0;
    case (a)
      2'd0: if (we) begin
              m_wh = 0;
              if (q.size() == DEPTH) begin er = 1; m_ovf = 1; end
              else q.push_back(wd);
            end else begin
              m_rh = 0;
              if (q.size() == 0) begin er = 1; m_udf = 1; ed = '0; end
              else ed = q.pop_front();
            end
      2'd1: if (we) begin
              if (wd[3]) m_ovf = 0;
              if (wd[2]) m_udf = 0;
            end else ed = m_status();
      2'd2: if (we) begin
              m_en = wd[31]; m_wth = int'(wd[15:8]); m_rth = int'(wd[7:0]);
            end else ed = {m_en, 15'h0, 8'(m_wth), 8'(m_rth)};
      default: ed = '0;
    endcase
    model_acks(rack, wack);
    e = {!er, er, exp_rq(), exp_wq()};
  endtask

  // Idle cycle with optional DMA acknowledges; returns {rd_req,wr_req}.
  task automatic pulse(input bit rack, input bit wack, output logic [1:0] o, output logic [1:0] e);
    @(negedge clock);
    rd_ack_i = rack; wr_ack_i = wack;
    @(posedge clock); #1;
    o = {rd_req_o, wr_req_o};
    @(negedge clock);
    rd_ack_i = 0; wr_ack_i = 0;
    model_acks(rack, wack);
    e = {exp_rq(), exp_wq()};
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] od, ed; logic [3:0] o, e;
    @(negedge clock); reset = 1; #1;
    tests++;
    if ({wb.t_ack, wb.t_err, rd_req_o, wr_req_o, wb.t_dat_r} !== 36'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ack/err/rq/wq=%b%b%b%b dat=%h, want all 0",
               wb.t_ack, wb.t_err, rd_req_o, wr_req_o, wb.t_dat_r);
    end
    repeat (2) @(negedge clock);
    reset = 0; model_reset();
    bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
    tests++;
    if (od !== 32'h0000_0001 || o !== 4'b1000) begin
      fails++; $display("FAIL reset_status: got %h flags %b, want 00000001 flags 1000", od, o);
    end
    bus(0, 2'd2, 0, 0, 0, od, o, ed, e);
    tests++;
    if (od !== 32'h0000_0101 || o !== 4'b1000) begin
      fails++; $display("FAIL reset_ctrl: got %h flags %b, want 00000101 flags 1000", od, o);
    end
  endtask

  task automatic test_order();
    logic [31:0] od, ed; logic [3:0] o, e;
    bus(1, 2'd2, 32'h8000_0101, 0, 0, od, o, ed, e);
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 15; i++) begin
        bus(1, 2'd0, (pass == 0) ? 32'h11 + i : $urandom, 0, 0, od, o, ed, e);
        tests++;
        if (o !== e) begin fails++; $display("FAIL order_push: got %b want %b", o, e); end
      end
      bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
      tests++;
      if (od !== 32'h000F_0000) begin fails++; $display("FAIL order_count: got %h want 000f0000", od); end
      for (int i = 0; i < 15; i++) begin
        bus(0, 2'd0, 0, 0, 0, od, o, ed, e);
        tests++;
        if (o !== e || od !== ed || (pass == 0 && od !== 32'h11 + i)) begin
          fails++; $display("FAIL order_pop: got %h/%b want %h/%b", od, o, ed, e);
        end
      end
      bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
      tests++;
      if (od !== 32'h0000_0001) begin fails++; $display("FAIL order_empty: got %h want 00000001", od); end
    end
  endtask

  task automatic test_full();
    logic [31:0] od, ed; logic [3:0] o, e;
    for (int i = 0; i < DEPTH; i++) begin
      bus(1, 2'd0, $urandom, 0, 0, od, o, ed, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL full_push: got %b want %b", o, e); end
    end
    tests++;
    if (o[0] !== 1'b0) begin fails++; $display("FAIL full_wrreq: got %b want 0", o[0]); end
    bus(1, 2'd0, 32'hDEAD_BEEF, 0, 0, od, o, ed, e);
    tests++;
    if (o[3:2] !== 2'b01) begin fails++; $display("FAIL full_ovf_err: got ack/err %b want 01", o[3:2]); end
    bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
    tests++;
    if (od !== 32'h0010_000A) begin fails++; $display("FAIL full_status: got %h want 0010000a", od); end
    bus(1, 2'd1, 32'h8, 0, 0, od, o, ed, e);
    bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
    tests++;
    if (od !== 32'h0010_0002) begin fails++; $display("FAIL full_ovf_clr: got %h want 00100002", od); end
  endtask

  task automatic test_empty();
    logic [31:0] od, ed; logic [3:0] o, e;
    for (int i = 0; i < DEPTH; i++) begin
      bus(0, 2'd0, 0, 0, 0, od, o, ed, e);
      tests++;
      if (o !== e || od !== ed) begin fails++; $display("FAIL empty_drain: got %h/%b want %h/%b", od, o, ed, e); end
    end
    bus(0, 2'd0, 0, 0, 0, od, o, ed, e);
    tests++;
    if (o[3:2] !== 2'b01 || od !== 32'h0) begin
      fails++; $display("FAIL empty_udf_err: got ack/err %b dat %h want 01 / 0", o[3:2], od);
    end
    bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
    tests++;
    if (od !== 32'h0000_0005) begin fails++; $display("FAIL empty_status: got %h want 00000005", od); end
    bus(1, 2'd1, 32'h4, 0, 0, od, o, ed, e);
    bus(0, 2'd1, 0, 0, 0, od, o, ed, e);
    tests++;
    if (od !== 32'h0000_0001) begin fails++; $display("FAIL empty_udf_clr: got %h want 00000001", od); end
  endtask

  task automatic test_thresholds();
    logic [31:0] od, ed; logic [3:0] o, e;
    bus(1, 2'd2, 32'h8000_0404, 0, 0, od, o, ed, e);
    for (int i = 1; i <= 13; i++) begin
      bus(1, 2'd0, $urandom, 0, 0, od, o, ed, e);
      tests++;
      if (o !== e || o[1] !== (i >= 4) || o[0] !== (i <= 12)) begin
        fails++; $display("FAIL thresh_push%0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_holdoff();
    logic [31:0] od, ed; logic [3:0] o, e; logic [1:0] p, pe;
    pulse(1, 0, p, pe);
    tests++;
    if (p[1] !== 1'b0 || p !== pe) begin fails++; $display("FAIL hold_set: got %b want %b", p, pe); end
    for (int i = 0; i < 3; i++) begin
      pulse(0, 0, p, pe);
      tests++;
      if (p[1] !== 1'b0) begin fails++; $display("FAIL hold_idle: got rd_req %b want 0", p[1]); end
    end
    bus(0, 2'd0, 0, 0, 0, od, o, ed, e);
    tests++;
    if (o[1] !== 1'b1 || o !== e || od !== ed) begin
      fails++; $display("FAIL hold_release: got %h/%b want %h/%b", od, o, ed, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] od, ed, wd; logic [3:0] o, e; logic [1:0] p, pe;
    int r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        pulse($urandom_range(0, 1), $urandom_range(0, 1), p, pe);
        tests++;
        if (p !== pe) begin fails++; $display("FAIL rand_pulse%0d: got %b want %b", n, p, pe); end
      end else begin
        logic [1:0] a; bit we;
        we = $urandom_range(0, 1);
        a  = (r < 70) ? 2'd0 : 2'($urandom_range(1, 3));
        wd = $urandom;
        if (a == 2'd2 && we)
          wd = {($urandom_range(0, 7) != 0), 15'h0, 8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))};
        bus(we, a, wd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), od, o, ed, e);
        tests++;
        if (o !== e || (!we && od !== ed)) begin
          fails++; $display("FAIL rand_access%0d a=%0d we=%0d: got %h/%b want %h/%b", n, a, we, od, o, ed, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    wb.t_cyc = 1; wb.t_stb = 1; wb.t_we = 0; wb.t_adr = 32'h4;
    @(posedge clock); #2;
    reset = 1; #1;
    tests++;
    if ({wb.t_ack, wb.t_err, rd_req_o, wr_req_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_mid: got %b want 0000", {wb.t_ack, wb.t_err, rd_req_o, wr_req_o});
    end
    @(negedge clock);
    wb.t_cyc = 0; wb.t_stb = 0;
    reset = 0; model_reset();
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1; rd_ack_i = 0; wr_ack_i = 0;
    wb.t_cyc = 0; wb.t_stb = 0; wb.t_we = 0; wb.t_adr = '0; wb.t_dat_w = '0; wb.t_sel = '0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 0;
    test_reset();
    test_order();
    test_full();
    test_empty();
    test_thresholds();
    test_holdoff();
    test_random();
    test_reset_mid();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
